// File: rtl/toaster_pkg.sv
// Shared types and constants for the toaster control path.
// Optional abort support is selected with the TOASTER_ABORT_EN macro in toaster_top.
package toaster_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WARMUP    = 2'b01,
    TOAST     = 2'b10,
    COOL_DOWN = 2'b11
  } state_t;

  localparam int DEF_WARMUP_CYCLES = 4;
  localparam int DEF_TOAST_CYCLES  = 8;
  localparam int DEF_COOL_CYCLES   = 4;

  // Wide enough for the longest phase load value (darkness 3 toast).
  function automatic int timer_width(input int w, input int t, input int c);
    int m;
    m = w;
    if (3 * t > m) m = 3 * t;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/toaster_timer.sv
// Loadable phase down-counter; holds at zero until reloaded.
module toaster_timer #(
  parameter int WIDTH = 4
) (
  input  logic             iiClk,
  input  logic             iiRst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] timer;

  always_ff @(posedge iiClk) begin
    if (iiRst) begin
      timer <= '0;
    end else if (load) begin
      timer <= load_val;
    end else if (timer != '0) begin
      timer <= timer - WIDTH'(1);
    end
  end

  assign zero = (timer == '0);

endmodule

// File: rtl/toaster_top.sv
// Toaster sequencing FSM: IDLE -> WARMUP -> TOAST -> COOL_DOWN -> IDLE.
// Define TOASTER_ABORT_EN to let a zero command abort WARMUP/TOAST into COOL_DOWN.
module toaster_top
  import toaster_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int TOAST_CYCLES  = DEF_TOAST_CYCLES,
  parameter int COOL_CYCLES   = DEF_COOL_CYCLES
) (
  input  logic       iiClk,
  input  logic       iiRst,
  input  logic [1:0] iiA,
  output logic [1:0] oState,
  output logic       oHeater,
  output logic       oDone
);

  localparam int TW = timer_width(WARMUP_CYCLES, TOAST_CYCLES, COOL_CYCLES);
  localparam logic [TW-1:0] WARM_LOAD = TW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LOAD = TW'(COOL_CYCLES - 1);

  logic [1:0]    state_int;
  state_t        next_state;
  logic [1:0]    level, level_next;
  logic          armed, armed_next;
  logic          aborted, aborted_next;
  logic          done_next;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          abort_req;

`ifdef TOASTER_ABORT_EN
  assign abort_req = (iiA == 2'd0);
`else
  assign abort_req = 1'b0;
`endif

  toaster_timer #(.WIDTH(TW)) u_timer (
    .iiClk    (iiClk),
    .iiRst    (iiRst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    next_state   = state_t'(state_int);
    level_next   = level;
    armed_next   = armed;
    aborted_next = aborted;
    done_next    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_int)
      WARMUP: begin
        if (abort_req) begin
          next_state   = COOL_DOWN;
          tmr_load     = 1'b1;
          tmr_val      = COOL_LOAD;
          aborted_next = 1'b1;
        end else if (tmr_zero) begin
          next_state = TOAST;
          tmr_load   = 1'b1;
          tmr_val    = TW'(int'(level) * TOAST_CYCLES - 1);
        end
      end
      TOAST: begin
        // Abort wins even on the final toast cycle so oDone stays suppressed.
        if (abort_req) begin
          next_state   = COOL_DOWN;
          tmr_load     = 1'b1;
          tmr_val      = COOL_LOAD;
          aborted_next = 1'b1;
        end else if (tmr_zero) begin
          next_state = COOL_DOWN;
          tmr_load   = 1'b1;
          tmr_val    = COOL_LOAD;
        end
      end
      COOL_DOWN: begin
        if (tmr_zero) begin
          next_state = IDLE;
          done_next  = ~aborted;
        end
      end
      default: begin
        if (iiA == 2'd0) begin
          armed_next = 1'b1;
        end else if (armed) begin
          next_state   = WARMUP;
          level_next   = iiA;
          armed_next   = 1'b0;
          aborted_next = 1'b0;
          tmr_load     = 1'b1;
          tmr_val      = WARM_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge iiClk) begin
    if (iiRst) begin
      state_int <= IDLE;
      level     <= 2'd0;
      armed     <= 1'b1;
      aborted   <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      state_int <= next_state;
      level     <= level_next;
      armed     <= armed_next;
      aborted   <= aborted_next;
      oDone     <= done_next;
    end
  end

  assign oState  = state_int;
  assign oHeater = (state_int == WARMUP) || (state_int == TOAST);

endmodule

// File: tb/tb_toaster_top.sv
// Self-checking bench for toaster_top: phase-timeline model plus directed literal checks.
module tb_toaster_top;

  localparam int W = 4;
  localparam int T = 8;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       iiRst;
  logic [1:0] iiA;
  logic [1:0] oState;
  logic       oHeater;
  logic       oDone;

  int n_checks = 0;
  int n_fail   = 0;

  toaster_top #(
    .WARMUP_CYCLES (W),
    .TOAST_CYCLES  (T),
    .COOL_CYCLES   (C)
  ) dut (
    .iiClk   (clk),
    .iiRst   (iiRst),
    .iiA     (iiA),
    .oState  (oState),
    .oHeater (oHeater),
    .oDone   (oDone)
  );

  always #5 clk = ~clk;

  // Model: a started cycle is a timeline indexed by cycles elapsed since entering WARMUP.
  bit m_active = 1'b0;
  bit m_armed  = 1'b1;
  bit m_ab     = 1'b0;
  bit m_done   = 1'b0;
  int m_e      = 0;
  int m_cs     = 0;
  int m_lvl    = 0;

  // 1 warmup, 2 toast, 3 cool, 4 finished
  function automatic int phase(input int e);
    if (m_ab && e >= m_cs) return (e < m_cs + C) ? 3 : 4;
    if (e < W) return 1;
    if (e < W + m_lvl * T) return 2;
    if (e < W + m_lvl * T + C) return 3;
    return 4;
  endfunction

  always @(posedge clk) begin
    int cur;
    if (iiRst) begin
      m_active = 1'b0;
      m_armed  = 1'b1;
      m_done   = 1'b0;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (iiA != 2'd0 && m_armed) begin
        m_active = 1'b1;
        m_e      = 0;
        m_lvl    = int'(iiA);
        m_armed  = 1'b0;
        m_ab     = 1'b0;
      end else if (iiA == 2'd0) begin
        m_armed = 1'b1;
      end
    end else begin
      cur = phase(m_e);
`ifdef TOASTER_ABORT_EN
      if (iiA == 2'd0 && (cur == 1 || cur == 2)) begin
        m_ab = 1'b1;
        m_cs = m_e + 1;
      end
`endif
      m_e = m_e + 1;
      if (phase(m_e) == 4) begin
        m_active = 1'b0;
        m_done   = !m_ab;
      end else begin
        m_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int exp_s;
    exp_s = m_active ? phase(m_e) : 0;
    chk("state", int'(oState), exp_s);
    chk("state_int", int'(dut.state_int), exp_s);
    chk("heater", int'(oHeater), (exp_s == 1 || exp_s == 2) ? 1 : 0);
    chk("done", int'(oDone), int'(m_done));
  end

  int n_warm, n_toast, n_cool, n_done;

  task automatic clear_tally();
    n_warm = 0; n_toast = 0; n_cool = 0; n_done = 0;
  endtask

  task automatic cyc(input logic [1:0] a, input logic r);
    iiA   = a;
    iiRst = r;
    @(posedge clk);
    @(negedge clk);
    if (oState == 2'd1) n_warm++;
    if (oState == 2'd2) n_toast++;
    if (oState == 2'd3) n_cool++;
    if (oDone) n_done++;
  endtask

  task automatic chk_tally(input string tag, input int w, input int t, input int c, input int d);
    chk({tag, "_warm"}, n_warm, w);
    chk({tag, "_toast"}, n_toast, t);
    chk({tag, "_cool"}, n_cool, c);
    chk({tag, "_done"}, n_done, d);
  endtask

  initial begin
    logic [1:0] a;
    int n;
    iiA   = 2'd0;
    iiRst = 1'b1;
    clear_tally();
    cyc(2'd0, 1'b1);
    cyc(2'd0, 1'b1);
    chk("rst_state", int'(oState), 0);
    chk("rst_armed", int'(dut.armed), 1);
    chk("rst_level", int'(dut.level), 0);

    // Held command: one full cycle, no retrigger.
    clear_tally();
    repeat (40) cyc(2'd1, 1'b0);
    chk_tally("held1", 4, 8, 4, 1);

    // One-cycle darkness-3 pulse.
    repeat (2) cyc(2'd0, 1'b0);
    clear_tally();
    cyc(2'd3, 1'b0);
    repeat (40) cyc(2'd0, 1'b0);
`ifdef TOASTER_ABORT_EN
    chk_tally("pulse3", 1, 0, 4, 0);
`else
    chk_tally("pulse3", 4, 24, 4, 1);
`endif

    // Sweep 0->1->2->3->0; level stays latched at 1.
    repeat (5) cyc(2'd0, 1'b0);
    repeat (5) cyc(2'd1, 1'b0);
    repeat (5) cyc(2'd2, 1'b0);
    repeat (5) cyc(2'd3, 1'b0);
    chk("sweep_level", int'(dut.level), 1);
    repeat (30) cyc(2'd0, 1'b0);

    // Drop command in toast cycle 5.
    clear_tally();
    repeat (9) cyc(2'd2, 1'b0);
    chk("mid_toast_state", int'(oState), 2);
    repeat (30) cyc(2'd0, 1'b0);
`ifdef TOASTER_ABORT_EN
    chk_tally("abort_mid", 4, 5, 4, 0);
`else
    chk_tally("abort_mid", 4, 16, 4, 1);
`endif

    // Reset during TOAST, then immediate restart.
    repeat (6) cyc(2'd1, 1'b0);
    chk("pre_rst_toast", int'(oState), 2);
    cyc(2'd1, 1'b1);
    chk("rst_toast_state", int'(oState), 0);
    chk("rst_toast_heater", int'(oHeater), 0);
    chk("rst_toast_done", int'(oDone), 0);
    chk("rst_toast_armed", int'(dut.armed), 1);
    cyc(2'd1, 1'b0);
    chk("restart_state", int'(oState), 1);
    repeat (30) cyc(2'd0, 1'b0);

    // Abort on the final toast cycle.
    clear_tally();
    repeat (12) cyc(2'd1, 1'b0);
    repeat (20) cyc(2'd0, 1'b0);
`ifdef TOASTER_ABORT_EN
    chk_tally("abort_edge", 4, 8, 4, 0);
`else
    chk_tally("abort_edge", 4, 8, 4, 1);
`endif

    // Random segments with occasional reset.
    for (int s = 0; s < 80; s++) begin
      a = 2'($urandom_range(0, 3));
      n = int'($urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) cyc(a, 1'b1);
      repeat (n) cyc(a, 1'b0);
    end
    repeat (40) cyc(2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toaster_top.md
# toaster_top

Toaster sequencing controller: a four-state FSM (IDLE, WARMUP, TOAST, COOL_DOWN) that starts a toast cycle from a 2-bit darkness command and times each phase with a down-counter. The module is `toaster_top`, the top of the toaster control path. It exposes its encoded state on a port and as the internal signal `state_int`, which benches probe hierarchically.

## Interface
- `WARMUP_CYCLES`, default 4: cycles spent in WARMUP.
- `TOAST_CYCLES`, default 8: TOAST cycles per darkness level.
- `COOL_CYCLES`, default 4: cycles spent in COOL_DOWN.
- `iiClk` input 1: single clock; all logic updates on the rising edge.
- `iiRst` input 1: reset, synchronous and active-high.
- `iiA` input 2: darkness command. 0 = off/stop; 1..3 = darkness level.
- `oState` output 2: current state, equal to `state_int`.
- `oHeater` output 1: high in WARMUP and TOAST.
- `oDone` output 1: one-cycle pulse when a cycle completes without abort.

## Operation
- State encoding:
  - IDLE = 2'b00
  - WARMUP = 2'b01
  - TOAST = 2'b10
  - COOL_DOWN = 2'b11
- `state_int` is the state register. Declare it as a plain 2-bit logic vector so hierarchical readers can decode it.
- Internal registers:
  - `level` (2 bits): latched darkness.
  - `armed` (1 bit): start permitted.
  - `timer`: width is `$clog2(max(WARMUP_CYCLES, 3*TOAST_CYCLES, COOL_CYCLES)+1)`.
- IDLE:
  - If `iiA != 0` and `armed`: go to WARMUP, latch `level = iiA`, load `timer = WARMUP_CYCLES-1`, clear `armed`.
  - If `iiA == 0`: set `armed`.
- WARMUP: when `timer == 0`, go to TOAST and load `timer = level*TOAST_CYCLES-1`. Otherwise decrement `timer`.
- TOAST: when `timer == 0`, go to COOL_DOWN and load `timer = COOL_CYCLES-1`. Otherwise decrement.
- COOL_DOWN: when `timer == 0`, go to IDLE and pulse `oDone` in the first IDLE cycle. Skip the pulse if the cycle was aborted. Otherwise decrement.
- `level` is held for the whole cycle. Changes of `iiA` to another nonzero value mid-cycle are ignored.
- Re-arm rule: after returning to IDLE, a new cycle starts only after `iiA` has been sampled as 0 at least once in IDLE. A held nonzero command never retriggers.
- Abort (see Configuration): `iiA == 0` in WARMUP or TOAST goes to COOL_DOWN and loads `timer = COOL_CYCLES-1`. Abort takes priority over timer expiry.
- Encodings are fixed, so no illegal state exists. Any unreached value decodes to IDLE through the default branch.

## Timing
- Reset values: `state_int`/`oState` = IDLE, `oHeater` = 0, `oDone` = 0, `timer` = 0, `level` = 0, `armed` = 1.
- Reset asserted mid-cycle forces IDLE on the next edge, overriding all other conditions.
- `iiA` is sampled on the rising edge. The state changes on the same edge, giving one cycle of latency from command to WARMUP.
- Phase lengths are exact:
  - WARMUP: `WARMUP_CYCLES` cycles.
  - TOAST: `level*TOAST_CYCLES` cycles.
  - COOL_DOWN: `COOL_CYCLES` cycles.
- All outputs are registered or decoded from registered state. `oHeater` follows `state_int` combinationally.
- `oDone` is a registered single-cycle pulse coinciding with the first IDLE cycle.
- All parameters must be ≥ 1.

## Configuration
- `TOASTER_ABORT_EN` defined: abort as described in Operation; `oDone` is suppressed for aborted cycles.
- `TOASTER_ABORT_EN` undefined:
  - `iiA == 0` is ignored outside IDLE, and every started cycle runs to completion.
  - `oDone` always pulses at the end of the cycle.

## Structure
- Package `toaster_pkg`:
  - `state_t` enum with the fixed 2-bit encodings.
  - Default phase-length constants.
  - Timer width function.
- Sub-module `toaster_timer`: loadable down-counter with inputs `iiClk`, `iiRst`, `load`, `load_val`, and output `zero`.
- `toaster_top` holds the FSM, the `level`/`armed` registers and output decode.

## Test plan
- Defaults; reset 2 cycles; `iiA = 1` held → WARMUP 4 cycles, TOAST 8, COOL_DOWN 4, IDLE with `oDone = 1` for 1 cycle; no restart while `iiA` stays 1.
- `iiA = 3` pulse of one cycle then 0 → TOAST lasts 24 cycles. Abort build: `iiA = 0` after that single cycle aborts to COOL_DOWN during WARMUP and `oDone` stays 0. No-abort build: full 4+24+4 cycle run.
- Sweep `iiA` 0→1→2→3→0, 5 cycles each → decoded state follows the FSM rules above, `level` = 1, and `oState == state_int` every cycle.
- With `TOASTER_ABORT_EN`: `iiA = 2`, then drop to 0 in TOAST cycle 5 → COOL_DOWN next edge, `oHeater` = 0, no `oDone`.
- `iiRst` asserted in TOAST → IDLE next edge, all outputs 0, `armed` = 1, and an immediate `iiA = 1` restarts.
- Abort coinciding with TOAST `timer == 0` → COOL_DOWN, `oDone` suppressed.
